obi_rr_arbiter: RTL

// - Shares one OBI slave port (e.g. the e-GPU L2/main-memory bridge) between NUM_MASTERS OBI masters (CU fetch/LSU ports).
// - Request channel: round-robin arbitration. Response channel (rvalid/rdata): routed back to the issuing master.
// - Routing uses an in-order ID FIFO. The slave must return responses in request order, per the OBI spec.

---
 rtl/e_gpu_obi_pkg.sv | 28 ++
 rtl/obi_id_fifo.sv | 65 ++++++
 rtl/obi_rr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/e_gpu_obi_pkg.sv
// ---------------------------------------------------------------------------
// e_gpu_obi_pkg
// Shared OBI field widths and the request bundle used by the e-GPU memory
// arbitration blocks.
//   ADDR_W / DATA_W / BE_W : OBI address, data and byte-enable widths
//   obi_req_t              : one master's request-channel fields
//   rr_next()              : modulo increment for round-robin pointers
// ---------------------------------------------------------------------------
package e_gpu_obi_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } obi_req_t;

   // Index following v in a ring of n entries; n need not be a power of 2.
   function automatic int rr_next(input int v, input int n);
      return (v + 1) % n;
   endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_id_fifo
// Small in-order FIFO holding the master index of each accepted OBI request
// so responses can be steered back to the issuer.
//   clk, reset  : rising-edge clock, synchronous active-high reset (flush)
//   push, din   : write din when push=1 and not full
//   pop, dout   : dout is the head entry; pop=1 removes it when not empty
//   full, empty : occupancy flags
// Push and pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module obi_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/obi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// obi_rr_arbiter
// Shares one OBI slave port between NUM_MASTERS OBI masters.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   m_req_i/m_addr_i/m_we_i/m_be_i/m_wdata_i : per-master request channels,
//                          master i in slice i of each flattened bus
//   m_gnt_o              : per-master grant, one-hot or zero
//   m_rvalid_o           : per-master response valid, one-hot or zero
//   m_rdata_o            : response data broadcast to all masters
//   s_req_o ... s_wdata_o: muxed request to the slave
//   s_gnt_i, s_rvalid_i, s_rdata_i : slave grant / response
//   err_o                : sticky, response arrived with nothing outstanding
// Requests are picked round-robin; a stalled request stays selected until
// granted. Accepted master IDs queue in obi_id_fifo so in-order responses go
// back to their issuer.
// ---------------------------------------------------------------------------
module obi_rr_arbiter
   import e_gpu_obi_pkg::*;
#(
   parameter int NUM_MASTERS     = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_req_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS*BE_W-1:0]   m_be_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
   output logic [NUM_MASTERS-1:0]        m_gnt_o,
   output logic [NUM_MASTERS-1:0]        m_rvalid_o,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic                          s_req_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic                          s_we_o,
   output logic [BE_W-1:0]               s_be_o,
   output logic [DATA_W-1:0]             s_wdata_o,
   input  logic                          s_gnt_i,
   input  logic                          s_rvalid_i,
   input  logic [DATA_W-1:0]             s_rdata_i,
   output logic                          err_o
);

   localparam int IW = $clog2(NUM_MASTERS);

   obi_req_t        m_req [NUM_MASTERS];
   obi_req_t        s_bus;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   locked_idx;
   logic [IW-1:0]   rr_sel;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   head;
   logic            lock;
   logic            err_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic            s_req;
   logic            accept;
   logic            rsp_ok;

   // Unflatten the master buses into request bundles.
   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign m_req[i].req   = m_req_i[i];
      assign m_req[i].addr  = m_addr_i[ADDR_W*i +: ADDR_W];
      assign m_req[i].we    = m_we_i[i];
      assign m_req[i].be    = m_be_i[BE_W*i +: BE_W];
      assign m_req[i].wdata = m_wdata_i[DATA_W*i +: DATA_W];
   end

   // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
   always_comb begin
      logic found;
      int   idx;
      rr_sel = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_MASTERS;
         if (!found && m_req_i[idx]) begin
            rr_sel = IW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign sel = lock ? locked_idx : rr_sel;

   // A full ID FIFO blocks requests even when a pop happens this cycle.
   assign s_req  = ~reset & (lock | (|m_req_i)) & ~fifo_full;
   assign accept = s_req & s_gnt_i;
   assign rsp_ok = ~reset & s_rvalid_i & ~fifo_empty;

   // Slave request fields are forced to zero when no request is presented.
   always_comb begin
      s_bus     = m_req[sel];
      s_bus.req = s_req;
      if (!s_req) s_bus = '0;
   end

   assign s_req_o   = s_bus.req;
   assign s_addr_o  = s_bus.addr;
   assign s_we_o    = s_bus.we;
   assign s_be_o    = s_bus.be;
   assign s_wdata_o = s_bus.wdata;

   always_comb begin
      m_gnt_o = '0;
      if (accept) m_gnt_o[sel] = 1'b1;
   end

   // Responses always go to the oldest outstanding ID, never to one being
   // pushed in the same cycle.
   always_comb begin
      m_rvalid_o = '0;
      if (rsp_ok) m_rvalid_o[head] = 1'b1;
   end

   assign m_rdata_o = s_rdata_i;
   assign err_o     = err_q;

   obi_id_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (rsp_ok),
      .din   (sel),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= '0;
         lock       <= 1'b0;
         locked_idx <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr <= IW'(rr_next(int'(sel), NUM_MASTERS));
            lock   <= 1'b0;
         end else if (s_req) begin
            // Stalled request: freeze selection until the slave grants it.
            lock       <= 1'b1;
            locked_idx <= sel;
         end
         if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
      end
   end

endmodule
